// File: rtl/gate_share_arbiter.sv
// rtl/gate_share_arbiter.sv - round-robin arbiter sharing one W-bit bitwise logic unit
//
// Purpose: N_REQ requesters post (A, B, OP); one winner per cycle is evaluated
// by the shared logic unit and the result is registered with the winner's ID.
//
// Ports:
//   CLK    in   clock, rising edge
//   RST    in   synchronous active-high reset
//   REQ    in   [N_REQ]     per-requester request valid
//   A, B   in   [N_REQ*W]   operands, requester i at [i*W +: W]
//   OP     in   [N_REQ*3]   opcode, requester i at [i*3 +: 3]
//   GNT    out  [N_REQ]     one-hot combinational grant
//   Y      out  [W]         registered result
//   Y_VLD  out              result valid
//   Y_ID   out  [IDW]       requester that produced Y
//   Y_RDY  in               downstream ready
//   BUSY   out              result pending or any request present
module gate_share_arbiter #(
   parameter int N_REQ = 4,
   parameter int W     = 8,
   parameter int IDW   = 2
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [N_REQ-1:0]     REQ,
   input  logic [N_REQ*W-1:0]   A,
   input  logic [N_REQ*W-1:0]   B,
   input  logic [N_REQ*3-1:0]   OP,
   output logic [N_REQ-1:0]     GNT,
   output logic [W-1:0]         Y,
   output logic                 Y_VLD,
   output logic [IDW-1:0]       Y_ID,
   input  logic                 Y_RDY,
   output logic                 BUSY
);

   logic [IDW-1:0] last;
   logic           accept;
   logic           found;
   logic [IDW-1:0] idx;
   logic [IDW-1:0] win;
   logic [W-1:0]   win_a;
   logic [W-1:0]   win_b;
   logic [2:0]     win_op;
   logic [W-1:0]   alu_y;

   // Output slot can take a new result if empty or being drained this edge.
   assign accept = ~Y_VLD | Y_RDY;
   assign BUSY   = Y_VLD | (|REQ);

   // Search upward from last+1; IDW-bit arithmetic wraps modulo N_REQ.
   always_comb begin
      GNT    = '0;
      found  = 1'b0;
      idx    = '0;
      win    = '0;
      win_a  = '0;
      win_b  = '0;
      win_op = '0;
      if (!RST && accept) begin
         for (int i = 0; i < N_REQ; i++) begin
            idx = last + IDW'(1) + IDW'(i);
            if (!found && REQ[idx]) begin
               found    = 1'b1;
               win      = idx;
               GNT[idx] = 1'b1;
               win_a    = A[idx*W +: W];
               win_b    = B[idx*W +: W];
               win_op   = OP[idx*3 +: 3];
            end
         end
      end
   end

   always_comb begin
      alu_y = '0;
      case (win_op)
         3'd0: alu_y = win_a & win_b;
         3'd1: alu_y = win_a | win_b;
         3'd2: alu_y = ~(win_a & win_b);
         3'd3: alu_y = ~(win_a | win_b);
         3'd4: alu_y = win_a ^ win_b;
         3'd5: alu_y = ~(win_a ^ win_b);
         3'd6: alu_y = ~win_a;
         default: alu_y = win_a;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         Y     <= '0;
         Y_VLD <= 1'b0;
         Y_ID  <= '0;
         last  <= IDW'(N_REQ - 1);
      end else if (found) begin
         // Grant replaces any result draining this same edge, no bubble.
         Y     <= alu_y;
         Y_ID  <= win;
         Y_VLD <= 1'b1;
         last  <= win;
      end else if (Y_VLD && Y_RDY) begin
         Y_VLD <= 1'b0;
      end
   end

endmodule

// File: tb/tb_gate_share_arbiter.sv
// tb/tb_gate_share_arbiter.sv - directed self-checking bench for gate_share_arbiter
module tb_gate_share_arbiter;

   localparam int N_REQ = 4;
   localparam int W     = 8;
   localparam int IDW   = 2;

   logic                 CLK;
   logic                 RST;
   logic [N_REQ-1:0]     REQ;
   logic [N_REQ*W-1:0]   A;
   logic [N_REQ*W-1:0]   B;
   logic [N_REQ*3-1:0]   OP;
   logic [N_REQ-1:0]     GNT;
   logic [W-1:0]         Y;
   logic                 Y_VLD;
   logic [IDW-1:0]       Y_ID;
   logic                 Y_RDY;
   logic                 BUSY;

   int checks;
   int failures;

   logic [7:0] sweep_exp [8];

   gate_share_arbiter #(.N_REQ(N_REQ), .W(W), .IDW(IDW)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .REQ   (REQ),
      .A     (A),
      .B     (B),
      .OP    (OP),
      .GNT   (GNT),
      .Y     (Y),
      .Y_VLD (Y_VLD),
      .Y_ID  (Y_ID),
      .Y_RDY (Y_RDY),
      .BUSY  (BUSY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      sweep_exp[0] = 8'h88; sweep_exp[1] = 8'hEE; sweep_exp[2] = 8'h77; sweep_exp[3] = 8'h11;
      sweep_exp[4] = 8'h66; sweep_exp[5] = 8'h99; sweep_exp[6] = 8'h33; sweep_exp[7] = 8'hCC;

      // Reset with all requests present: no grant allowed during reset.
      RST   = 1'b1;
      REQ   = 4'b1111;
      A     = '0;
      B     = '0;
      OP    = '0;
      Y_RDY = 1'b1;
      #1;
      check("gnt_in_reset", 32'(GNT), 32'h0);
      step();
      check("rst_y", 32'(Y), 32'h0);
      check("rst_vld", 32'(Y_VLD), 32'h0);
      check("rst_id", 32'(Y_ID), 32'h0);
      REQ = '0;
      RST = 1'b0;
      #1;
      check("idle_busy", 32'(BUSY), 32'h0);

      // Single request, NOR.
      REQ = 4'b0001;
      A[0 +: W] = 8'hF0;
      B[0 +: W] = 8'h0F;
      OP[0 +: 3] = 3'd3;
      #1;
      check("single_gnt", 32'(GNT), 32'h1);
      step();
      REQ = '0;
      check("single_y", 32'(Y), 32'h00);
      check("single_vld", 32'(Y_VLD), 32'h1);
      check("single_id", 32'(Y_ID), 32'h0);
      check("single_busy", 32'(BUSY), 32'h1);
      step();
      check("drain_vld", 32'(Y_VLD), 32'h0);

      // Re-reset so round robin starts at requester 0, then all request OR.
      RST = 1'b1;
      step();
      RST = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         A[i*W +: W]  = 8'(i);
         B[i*W +: W]  = 8'h10;
         OP[i*3 +: 3] = 3'd1;
      end
      REQ = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         #1;
         check($sformatf("rr_gnt%0d", k), 32'(GNT), 32'(1 << (k % 4)));
         step();
         check($sformatf("rr_y%0d", k), 32'(Y), 32'h10 | 32'(k % 4));
         check($sformatf("rr_id%0d", k), 32'(Y_ID), 32'(k % 4));
         check($sformatf("rr_vld%0d", k), 32'(Y_VLD), 32'h1);
      end

      // Backpressure: Y holds 0x10 from requester 0; requester 1 waits.
      REQ   = 4'b0010;
      Y_RDY = 1'b0;
      A[1*W +: W]  = 8'h55;
      B[1*W +: W]  = 8'h0F;
      OP[1*3 +: 3] = 3'd4;
      for (int k = 0; k < 3; k++) begin
         #1;
         check($sformatf("bp_gnt%0d", k), 32'(GNT), 32'h0);
         step();
         check($sformatf("bp_y%0d", k), 32'(Y), 32'h10);
         check($sformatf("bp_id%0d", k), 32'(Y_ID), 32'h0);
         check($sformatf("bp_vld%0d", k), 32'(Y_VLD), 32'h1);
      end
      Y_RDY = 1'b1;
      #1;
      check("bp_release_gnt", 32'(GNT), 32'h2);
      step();
      check("bp_release_y", 32'(Y), 32'h5A);
      check("bp_release_id", 32'(Y_ID), 32'h1);

      // Move LAST to 3, then check wrap-around priority.
      REQ = 4'b1000;
      #1;
      check("to3_gnt", 32'(GNT), 32'h8);
      step();
      REQ = 4'b1001;
      #1;
      check("wrap_gnt0", 32'(GNT), 32'h1);
      step();
      check("wrap_id0", 32'(Y_ID), 32'h0);
      check("wrap_gnt3", 32'(GNT), 32'h8);
      step();
      check("wrap_id3", 32'(Y_ID), 32'h3);

      // Opcode sweep on requester 2.
      A[2*W +: W] = 8'hCC;
      B[2*W +: W] = 8'hAA;
      REQ = 4'b0100;
      for (int k = 0; k < 8; k++) begin
         OP[2*3 +: 3] = 3'(k);
         #1;
         check($sformatf("op%0d_gnt", k), 32'(GNT), 32'h4);
         step();
         check($sformatf("op%0d_y", k), 32'(Y), 32'(sweep_exp[k]));
         check($sformatf("op%0d_id", k), 32'(Y_ID), 32'h2);
      end

      // Reset while a result is stalled.
      Y_RDY = 1'b0;
      REQ   = 4'b0110;
      #1;
      check("stall_gnt", 32'(GNT), 32'h0);
      RST = 1'b1;
      #1;
      check("midrst_gnt", 32'(GNT), 32'h0);
      step();
      check("midrst_vld", 32'(Y_VLD), 32'h0);
      check("midrst_y", 32'(Y), 32'h0);
      RST   = 1'b0;
      Y_RDY = 1'b1;
      #1;
      check("postrst_gnt", 32'(GNT), 32'h2);
      step();
      check("postrst_id", 32'(Y_ID), 32'h1);
      check("postrst_vld", 32'(Y_VLD), 32'h1);
      REQ = '0;
      step();
      check("final_busy", 32'(BUSY), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gate_share_arbiter.md
Name: gate_share_arbiter

Overview:
- Round-robin arbiter and sequencer for one shared W-bit bitwise logic unit (AND/OR/NAND/NOR/XOR/XNOR/NOT/PASS).
- Up to N_REQ requesters post operand pairs and an opcode.
- The arbiter grants one requester per cycle, evaluates the operation, and returns a registered result tagged with the requester ID.
- The result output has a valid/ready handshake with backpressure.

Parameters:
- N_REQ, 4, number of requesters; power of two, 2..16.
- W, 8, operand/result width in bits.
- IDW, 2, requester ID width; must equal log2(N_REQ).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous active-high reset.
- REQ  in  N_REQ  per-requester request valid.
- A  in  N_REQ*W  operand A; requester i occupies bits [i*W +: W].
- B  in  N_REQ*W  operand B; same packing as A.
- OP  in  N_REQ*3  opcode; requester i occupies bits [i*3 +: 3].
- GNT  out  N_REQ  one-hot grant, combinational; transfer occurs at the edge where GNT[i] & REQ[i].
- Y  out  W  registered result.
- Y_VLD  out  1  result valid.
- Y_ID  out  IDW  index of the requester that produced Y.
- Y_RDY  in  1  downstream ready; the result is consumed at the edge where Y_VLD & Y_RDY.
- BUSY  out  1  high when Y_VLD=1 or any REQ bit is set.

Behaviour:
- Reset (RST=1 at an edge):
  - Y=0, Y_VLD=0, Y_ID=0.
  - Round-robin pointer LAST=N_REQ-1, so requester 0 has highest priority first.
  - GNT is all zeros while RST=1.
  - A reset mid-transaction drops a pending result; no grant is issued in a reset cycle.
- Opcode encoding, applied bitwise over W bits:
  - 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR.
  - 6 ~A (B ignored), 7 A (pass).
- Accept condition: ACCEPT = ~Y_VLD | Y_RDY. The output slot is empty or is being drained this cycle.
- Grant rule:
  - When ACCEPT=1 and REQ!=0, GNT selects the first set REQ bit searching upward from LAST+1, modulo N_REQ.
  - Otherwise GNT=0.
  - GNT is exactly one-hot or zero, never multi-hot.
  - A requester with REQ=1 must hold A/B/OP stable until it sees its grant.
- On a grant edge (winner k):
  - Y <= f(OP_k, A_k, B_k).
  - Y_ID <= k.
  - Y_VLD <= 1.
  - LAST <= k.
- No-grant edges:
  - Y_VLD & Y_RDY with no grant: Y_VLD <= 0; Y and Y_ID are held.
  - Y_VLD & ~Y_RDY: Y, Y_ID and Y_VLD are held (stall); GNT=0.
- Latency and throughput:
  - Latency is 1 cycle from the grant edge to Y_VLD.
  - Sustained throughput is 1 result per cycle while Y_RDY=1.
- LAST changes only on grants.
- Fairness: any continuously asserted request is granted within N_REQ grants.
- Simultaneous drain and grant in the same cycle is legal. Y is replaced by the new result with no bubble.
- A REQ that deasserts before its grant is simply dropped; there is no internal queue.
- Wrap-around: after LAST=N_REQ-1 the search starts at index 0.
- Y_ID width and index arithmetic are modulo N_REQ.

Test Plan:
- Reset then single request: REQ=0001, A0=0xF0, B0=0x0F, OP0=3 (NOR) → GNT=0001 in the same cycle; next cycle Y=0x00, Y_VLD=1, Y_ID=0.
- All requests held with Y_RDY=1: REQ=1111, each OP=1, A_i=i, B_i=0x10 → grants in order 0,1,2,3,0; Y sequence 0x10,0x11,0x12,0x13,0x10; Y_VLD stays high continuously.
- Backpressure: while Y_VLD=1, hold Y_RDY=0 for 3 cycles with REQ=0010 → GNT=0 and Y/Y_ID stable for 3 cycles; when Y_RDY=1, GNT=0010 that same cycle and the new result appears the next cycle.
- Wrap-around priority: LAST=3, REQ=1001 → GNT=0001; then with REQ=1001 still held → GNT=1000.
- Opcode sweep: A=0xCC, B=0xAA, OP 0..7 → Y = 0x88, 0xEE, 0x77, 0x11, 0x66, 0x99, 0x33, 0xCC.
- Reset mid-operation: Y_VLD=1, Y_RDY=0, assert RST for 1 cycle → Y_VLD=0, Y=0, GNT=0 during reset; after reset, the next grant goes to the lowest-index active request.
